// File: rtl/operand_bus_tx_if.sv
// operand_bus_tx_if -- operand handshake bundle between a job source and
// operand_bus_tx.
//
//   op_valid  source -> tx   operand pair offered
//   op_ready  tx -> source   tx accepts the pair (handshake = valid & ready)
//   op_x      source -> tx   base operand, SIZE_INPUT bits
//   op_y      source -> tx   exponent operand, SIZE_INPUT bits
//
// master: the job source. slave: operand_bus_tx.
interface operand_bus_tx_if #(
  parameter int SIZE_INPUT = 512
);
  logic                  op_valid;
  logic                  op_ready;
  logic [SIZE_INPUT-1:0] op_x;
  logic [SIZE_INPUT-1:0] op_y;

  modport master (output op_valid, op_x, op_y, input op_ready);
  modport slave  (input op_valid, op_x, op_y, output op_ready);
endinterface

// File: rtl/operand_bus_tx.sv
// operand_bus_tx -- feeds an operand pair to an exponentiation core.
//
// Accepts one (x, y) pair, holds the core in reset for RST_CYCLES cycles,
// streams x then y LSB-slice-first over a SLICE_SIZE bus on consecutive
// cycles, then watches the core's fault flag for up to RUN_CYCLES cycles
// and issues a one-cycle report.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   op           operand handshake (slave side of operand_bus_tx_if)
//   abort        cancel the current job; puts the core back in reset
//   core_rst     registered reset to the core
//   bus_output   registered slice bus to the core, 0 outside SEND
//   core_flag    fault flag level from the core, only looked at in RUN
//   busy         job in progress (state != IDLE)
//   rpt_valid    one-cycle report strobe
//   rpt_flag     core_flag sampled at report time, held until next report
//   rpt_timeout  1 = run window expired, 0 = early exit on core_flag
module operand_bus_tx #(
  parameter int SIZE_INPUT = 512,
  parameter int SLICE_SIZE = 128,
  parameter int RST_CYCLES = 4,
  parameter int RUN_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_bus_tx_if.slave       op,
  input  logic                  abort,
  output logic                  core_rst,
  output logic [SLICE_SIZE-1:0] bus_output,
  input  logic                  core_flag,
  output logic                  busy,
  output logic                  rpt_valid,
  output logic                  rpt_flag,
  output logic                  rpt_timeout
);

  localparam int BEATS   = SIZE_INPUT / SLICE_SIZE;
  localparam int SLICES  = 2 * BEATS;
  // One shared counter serves the reset hold, the slice index and the run
  // window, so it must cover the largest of the three.
  localparam int CNT_MAX = (RUN_CYCLES > RST_CYCLES)
                           ? ((RUN_CYCLES > SLICES) ? RUN_CYCLES : SLICES)
                           : ((RST_CYCLES > SLICES) ? RST_CYCLES : SLICES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORE,
    SEND,
    RUN,
    REPORT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SIZE_INPUT-1:0]   x_q, x_d, y_q, y_d;
  logic                    core_rst_d;
  logic [SLICE_SIZE-1:0]   bus_d;
  logic                    rpt_valid_d, rpt_flag_d, rpt_timeout_d;
  logic                    ready;
  logic [2*SIZE_INPUT-1:0] payload;

  // Slice k of the transmitted stream is payload[k*SLICE_SIZE +: SLICE_SIZE]:
  // x slices first, then y slices, each LSB slice first.
  assign payload  = {y_q, x_q};
  assign ready    = (state_q == IDLE) && !rst;
  assign op.op_ready = ready;
  assign busy     = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    core_rst_d    = core_rst;
    bus_d         = '0;
    rpt_valid_d   = 1'b0;
    rpt_flag_d    = rpt_flag;
    rpt_timeout_d = rpt_timeout;

    if (abort && (state_q != IDLE)) begin
      // Core stays in reset until the next job's RESET_CORE completes.
      state_d    = IDLE;
      cnt_d      = '0;
      core_rst_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (abort) core_rst_d = 1'b1;
          if (op.op_valid && ready) begin
            x_d        = op.op_x;
            y_d        = op.op_y;
            core_rst_d = 1'b1;
            cnt_d      = '0;
            state_d    = RESET_CORE;
          end
        end
        RESET_CORE: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            // Release the core and put the first slice up on the same edge.
            core_rst_d = 1'b0;
            bus_d      = payload[SLICE_SIZE-1:0];
            cnt_d      = '0;
            state_d    = SEND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SEND: begin
          // cnt_q is the index of the slice currently on the bus.
          if (cnt_q == CNT_W'(SLICES - 1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
            bus_d = payload[(int'(cnt_q) + 1) * SLICE_SIZE +: SLICE_SIZE];
          end
        end
        RUN: begin
          // A flag on the expiry cycle still counts as an early exit.
          if (core_flag || (cnt_q == CNT_W'(RUN_CYCLES - 1))) begin
            rpt_valid_d   = 1'b1;
            rpt_flag_d    = core_flag;
            rpt_timeout_d = !core_flag;
            state_d       = REPORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPORT: begin
          // core_rst stays low so the core's result remains observable.
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      // NOTE: the operand registers are cleared too, so no stale job data
      // survives a reset; plain data storage would normally skip this.
      x_q         <= '0;
      y_q         <= '0;
      core_rst    <= 1'b1;
      bus_output  <= '0;
      rpt_valid   <= 1'b0;
      rpt_flag    <= 1'b0;
      rpt_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      core_rst    <= core_rst_d;
      bus_output  <= bus_d;
      rpt_valid   <= rpt_valid_d;
      rpt_flag    <= rpt_flag_d;
      rpt_timeout <= rpt_timeout_d;
    end
  end

endmodule

// File: tb/tb_operand_bus_tx.sv
// tb_operand_bus_tx -- bench for operand_bus_tx.
// Two instances: dut_d with default parameters and dut_s with RUN_CYCLES=16.
// sel chooses which one receives op_valid and is observed. Expected slices
// go into a queue when a job is offered and are popped as beats appear.
module tb_operand_bus_tx;

  localparam int SIZE_INPUT = 512;
  localparam int SLICE_SIZE = 128;
  localparam int BEATS      = SIZE_INPUT / SLICE_SIZE;
  localparam int RST_CYCLES = 4;
  localparam int RUN_S      = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  sel;
  logic                  op_valid;
  logic [SIZE_INPUT-1:0] op_x, op_y;
  logic                  abort, core_flag;

  operand_bus_tx_if #(.SIZE_INPUT(SIZE_INPUT)) op_d_if ();
  operand_bus_tx_if #(.SIZE_INPUT(SIZE_INPUT)) op_s_if ();

  assign op_d_if.op_valid = op_valid & ~sel;
  assign op_d_if.op_x     = op_x;
  assign op_d_if.op_y     = op_y;
  assign op_s_if.op_valid = op_valid & sel;
  assign op_s_if.op_x     = op_x;
  assign op_s_if.op_y     = op_y;

  logic                  d_core_rst, d_busy, d_rpt_valid, d_rpt_flag, d_rpt_timeout;
  logic                  s_core_rst, s_busy, s_rpt_valid, s_rpt_flag, s_rpt_timeout;
  logic [SLICE_SIZE-1:0] d_bus, s_bus;

  operand_bus_tx #(
    .SIZE_INPUT(SIZE_INPUT), .SLICE_SIZE(SLICE_SIZE), .RST_CYCLES(RST_CYCLES)
  ) dut_d (
    .clk(clk), .rst(rst), .op(op_d_if), .abort(abort),
    .core_rst(d_core_rst), .bus_output(d_bus), .core_flag(core_flag),
    .busy(d_busy), .rpt_valid(d_rpt_valid), .rpt_flag(d_rpt_flag),
    .rpt_timeout(d_rpt_timeout)
  );

  operand_bus_tx #(
    .SIZE_INPUT(SIZE_INPUT), .SLICE_SIZE(SLICE_SIZE), .RST_CYCLES(RST_CYCLES),
    .RUN_CYCLES(RUN_S)
  ) dut_s (
    .clk(clk), .rst(rst), .op(op_s_if), .abort(abort),
    .core_rst(s_core_rst), .bus_output(s_bus), .core_flag(core_flag),
    .busy(s_busy), .rpt_valid(s_rpt_valid), .rpt_flag(s_rpt_flag),
    .rpt_timeout(s_rpt_timeout)
  );

  // Observed outputs of the selected instance.
  logic                  o_ready, o_core_rst, o_busy, o_rpt_valid, o_rpt_flag, o_rpt_timeout;
  logic [SLICE_SIZE-1:0] o_bus;
  assign o_ready       = sel ? op_s_if.op_ready : op_d_if.op_ready;
  assign o_core_rst    = sel ? s_core_rst    : d_core_rst;
  assign o_busy        = sel ? s_busy        : d_busy;
  assign o_rpt_valid   = sel ? s_rpt_valid   : d_rpt_valid;
  assign o_rpt_flag    = sel ? s_rpt_flag    : d_rpt_flag;
  assign o_rpt_timeout = sel ? s_rpt_timeout : d_rpt_timeout;
  assign o_bus         = sel ? s_bus         : d_bus;

  int n_cmp = 0;
  int n_err = 0;
  logic [SLICE_SIZE-1:0] exp_q[$];

  task automatic check(input string tag, input logic [SIZE_INPUT-1:0] got,
                       input logic [SIZE_INPUT-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [SIZE_INPUT-1:0] rand_op();
    logic [SIZE_INPUT-1:0] r;
    for (int i = 0; i < SIZE_INPUT / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_core_rst"},    o_core_rst,    1);
    check({tag, "_bus"},         o_bus,         0);
    check({tag, "_ready"},       o_ready,       0);
    check({tag, "_busy"},        o_busy,        0);
    check({tag, "_rpt_valid"},   o_rpt_valid,   0);
    check({tag, "_rpt_flag"},    o_rpt_flag,    0);
    check({tag, "_rpt_timeout"}, o_rpt_timeout, 0);
  endtask

  // Called at a negedge with the block idle; returns at the negedge of the
  // first cycle after the handshake edge, with the inputs scrambled.
  task automatic start_job(input logic [SIZE_INPUT-1:0] x, input logic [SIZE_INPUT-1:0] y);
    op_valid = 1'b1;
    op_x     = x;
    op_y     = y;
    #1;
    check("hs_ready", o_ready, 1);
    for (int b = 0; b < BEATS; b++) exp_q.push_back(x[b*SLICE_SIZE +: SLICE_SIZE]);
    for (int b = 0; b < BEATS; b++) exp_q.push_back(y[b*SLICE_SIZE +: SLICE_SIZE]);
    tick();
    op_valid = 1'b0;
    op_x     = ~x;
    op_y     = rand_op();
  endtask

  // Core reset hold then 2*BEATS beats; abort_beat >= 0 aborts while that
  // beat is on the bus. Ends at the negedge of run cycle 0 (or after abort).
  task automatic check_send(input int abort_beat);
    for (int c = 0; c < RST_CYCLES; c++) begin
      check($sformatf("hold%0d_core_rst", c), o_core_rst, 1);
      check($sformatf("hold%0d_bus", c),      o_bus,      0);
      check($sformatf("hold%0d_busy", c),     o_busy,     1);
      check($sformatf("hold%0d_ready", c),    o_ready,    0);
      tick();
    end
    for (int b = 0; b < 2*BEATS; b++) begin
      check($sformatf("beat%0d_core_rst", b), o_core_rst, 0);
      check($sformatf("beat%0d_bus", b),      o_bus,      exp_q.pop_front());
      if (b == abort_beat) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",      o_busy,      0);
        check("abort_core_rst",  o_core_rst,  1);
        check("abort_bus",       o_bus,       0);
        check("abort_rpt_valid", o_rpt_valid, 0);
        check("abort_ready",     o_ready,     1);
        exp_q.delete();
        return;
      end
      tick();
    end
    check("run0_bus",      o_bus,      0);
    check("run0_busy",     o_busy,     1);
    check("run0_core_rst", o_core_rst, 0);
  endtask

  // From run cycle 0: optionally raise core_flag during run cycle flag_at,
  // expect the report strobe in run cycle rpt_at, then idle.
  task automatic run_and_report(input int flag_at, input int rpt_at, input logic exp_timeout);
    for (int k = 0; k < rpt_at; k++) begin
      check($sformatf("run%0d_rpt_valid", k), o_rpt_valid, 0);
      if (k == flag_at) core_flag = 1'b1;
      tick();
    end
    check("rpt_valid",   o_rpt_valid,   1);
    check("rpt_flag",    o_rpt_flag,    (flag_at >= 0) ? 1 : 0);
    check("rpt_timeout", o_rpt_timeout, exp_timeout);
    check("rpt_busy",    o_busy,        1);
    core_flag = 1'b0;
    tick();
    check("post_rpt_valid",    o_rpt_valid, 0);
    check("post_rpt_ready",    o_ready,     1);
    check("post_rpt_busy",     o_busy,      0);
    check("post_rpt_core_rst", o_core_rst,  0);
    check("post_rpt_bus",      o_bus,       0);
    check("post_rpt_flag",     o_rpt_flag,  (flag_at >= 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZE_INPUT-1:0] x, y;
    sel = 1'b0; op_valid = 1'b0; op_x = '0; op_y = '0;
    abort = 1'b0; core_flag = 1'b0; rst = 1'b1;
    repeat (2) tick();
    check_reset_state("rst_d");
    sel = 1'b1;
    #1;
    check_reset_state("rst_s");
    sel = 1'b0;
    rst = 1'b0;
    tick();

    // Counting pattern: x slice n = n+1, y slice n = 2*(n+1).
    for (int n = 0; n < BEATS; n++) begin
      x[n*SLICE_SIZE +: SLICE_SIZE] = SLICE_SIZE'(n + 1);
      y[n*SLICE_SIZE +: SLICE_SIZE] = SLICE_SIZE'(2 * (n + 1));
    end
    start_job(x, y);
    check_send(-1);
    run_and_report(10, 11, 1'b0);

    // Abort while idle only raises core_rst.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_core_rst", o_core_rst, 1);
    check("idle_abort_busy",     o_busy,     0);
    check("idle_abort_ready",    o_ready,    1);
    check("idle_abort_rpt_flag", o_rpt_flag, 1);

    // Abort on beat 3, then the same job replays from slice 0.
    x = rand_op();
    y = rand_op();
    start_job(x, y);
    check_send(3);
    start_job(x, y);
    check_send(-1);
    run_and_report(0, 1, 1'b0);

    // Reset during RUN with op_valid held through reset.
    start_job(rand_op(), rand_op());
    check_send(-1);
    repeat (3) tick();
    x = rand_op();
    y = rand_op();
    rst = 1'b1; op_valid = 1'b1; op_x = x; op_y = y;
    exp_q.delete();
    tick();
    check_reset_state("rst_run");
    rst = 1'b0;
    start_job(x, y);
    check_send(-1);
    run_and_report(2, 3, 1'b0);

    // Short run window: expiry, then flag on the expiry cycle.
    sel = 1'b1;
    tick();
    start_job(rand_op(), rand_op());
    check_send(-1);
    run_and_report(-1, RUN_S, 1'b1);
    start_job(rand_op(), rand_op());
    check_send(-1);
    run_and_report(RUN_S - 1, RUN_S, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
